// File: rtl/sync_fifo_pkg.sv
// Shared helpers and default threshold levels for sync_fifo_param.
// Integrators use these when instantiating the FIFO.
package sync_fifo_pkg;

  localparam int DEF_DATA_W   = 8;
  localparam int DEF_DEPTH    = 16;
  localparam int DEF_AE_LEVEL = 2;

  function automatic int addr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int def_af_level(input int depth);
    return depth - 2;
  endfunction

endpackage

// File: rtl/sync_fifo_param_fifo_ram.sv
// Flop-array storage for sync_fifo_param.
// Synchronous write, combinational read, no reset on the array.
module fifo_ram
  import sync_fifo_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int ADDR_W = addr_width(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with flush, threshold flags and error pulses.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through output.
module sync_fifo_param
  import sync_fifo_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int ADDR_W   = $clog2(DEPTH),
  parameter int AF_LEVEL = def_af_level(DEPTH),
  parameter int AE_LEVEL = DEF_AE_LEVEL
) (
  input  logic              clk,
  input  logic              rst_an,
  input  logic              clr,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] data_in,
  input  logic              rd_en,
  output logic [DATA_W-1:0] data_out,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              underflow
);

  localparam logic [ADDR_W:0]   CNT_FULL = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   CNT_AF   = (ADDR_W+1)'(AF_LEVEL);
  localparam logic [ADDR_W:0]   CNT_AE   = (ADDR_W+1)'(AE_LEVEL);
  localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [DATA_W-1:0] rd_data;
  logic              wr_ok;
  logic              rd_ok;

  assign wr_ok = wr_en & ~full;
  assign rd_ok = rd_en & ~empty;

  fifo_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .we    (wr_ok & ~clr),
    .waddr (wr_ptr),
    .wdata (data_in),
    .raddr (rd_ptr),
    .rdata (rd_data)
  );

  always_ff @(posedge clk or negedge rst_an) begin
    if (!rst_an) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (clr) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + PTR_ONE;
      if (rd_ok) rd_ptr <= rd_ptr + PTR_ONE;
      unique case ({wr_ok, rd_ok})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
      overflow  <= wr_en & full;
      underflow <= rd_en & empty;
    end
  end

  assign full         = (count == CNT_FULL);
  assign empty        = (count == '0);
  assign almost_full  = (count >= CNT_AF);
  assign almost_empty = (count <= CNT_AE);

`ifdef SYNC_FIFO_FWFT_EN
  // Head word is exposed directly; rd_en only acknowledges it.
  assign data_out = empty ? '0 : rd_data;
`else
  logic [DATA_W-1:0] dout_q;

  always_ff @(posedge clk or negedge rst_an) begin
    if (!rst_an) begin
      dout_q <= '0;
    end else if (clr) begin
      dout_q <= '0;
    end else if (rd_ok) begin
      dout_q <= rd_data;
    end
  end

  assign data_out = dout_q;
`endif

endmodule

// File: tb/tb_sync_fifo_param.sv
// Self-checking bench for sync_fifo_param against a queue-based model.
// Directed scenarios followed by a randomized burst.
module tb_sync_fifo_param;

  localparam int DW  = 8;
  localparam int DP  = 16;
  localparam int AW  = 4;
  localparam int AFL = 14;
  localparam int AEL = 2;

  logic          clk;
  logic          rst_an;
  logic          clr;
  logic          wr_en;
  logic [DW-1:0] data_in;
  logic          rd_en;
  logic [DW-1:0] data_out;
  logic          full;
  logic          empty;
  logic          almost_full;
  logic          almost_empty;
  logic [AW:0]   count;
  logic          overflow;
  logic          underflow;

  sync_fifo_param #(
    .DATA_W   (DW),
    .DEPTH    (DP),
    .AF_LEVEL (AFL),
    .AE_LEVEL (AEL)
  ) dut (
    .clk          (clk),
    .rst_an       (rst_an),
    .clr          (clr),
    .wr_en        (wr_en),
    .data_in      (data_in),
    .rd_en        (rd_en),
    .data_out     (data_out),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] q[$];
  logic [DW-1:0] m_dout;
  logic          m_ovf;
  logic          m_unf;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] exp_dout();
`ifdef SYNC_FIFO_FWFT_EN
    return (q.size() == 0) ? '0 : q[0];
`else
    return m_dout;
`endif
  endfunction

  task automatic check_all(input string tag);
    int n;
    n = q.size();
    chk({tag, ".count"}, 32'(count), 32'(n));
    chk({tag, ".full"}, 32'(full), 32'(n == DP));
    chk({tag, ".empty"}, 32'(empty), 32'(n == 0));
    chk({tag, ".afull"}, 32'(almost_full), 32'(n >= AFL));
    chk({tag, ".aempty"}, 32'(almost_empty), 32'(n <= AEL));
    chk({tag, ".ovf"}, 32'(overflow), 32'(m_ovf));
    chk({tag, ".unf"}, 32'(underflow), 32'(m_unf));
    chk({tag, ".dout"}, 32'(data_out), 32'(exp_dout()));
  endtask

  task automatic model_reset();
    q.delete();
    m_dout = '0;
    m_ovf  = 1'b0;
    m_unf  = 1'b0;
  endtask

  task automatic step(input string tag, input logic w, input logic r,
                      input logic c, input logic [DW-1:0] d);
    bit was_full;
    bit was_empty;
    wr_en   = w;
    rd_en   = r;
    clr     = c;
    data_in = d;
    @(posedge clk);
    was_full  = (q.size() == DP);
    was_empty = (q.size() == 0);
    if (c) begin
      model_reset();
    end else begin
      m_ovf = w && was_full;
      m_unf = r && was_empty;
      if (r && !was_empty) m_dout = q.pop_front();
      if (w && !was_full) q.push_back(d);
    end
    #1;
    wr_en = 1'b0;
    rd_en = 1'b0;
    clr   = 1'b0;
    check_all(tag);
  endtask

  initial begin
    rst_an  = 1'b0;
    clr     = 1'b0;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    data_in = '0;
    model_reset();
    #1;
    check_all("reset");
    @(posedge clk);
    #1;
    rst_an = 1'b1;
    check_all("post_reset");

    for (int i = 0; i < DP; i++)
      step("fill", 1'b1, 1'b0, 1'b0, DW'(i));
    step("overflow", 1'b1, 1'b0, 1'b0, 8'hEE);
    step("ovf_clear", 1'b0, 1'b0, 1'b0, 8'h00);

    for (int i = 0; i < DP; i++)
      step("drain", 1'b0, 1'b1, 1'b0, 8'h00);
    step("underflow", 1'b0, 1'b1, 1'b0, 8'h00);
    step("unf_clear", 1'b0, 1'b0, 1'b0, 8'h00);

    for (int i = 0; i < DP; i++)
      step("refill", 1'b1, 1'b0, 1'b0, DW'(8'h40 + i));
    step("full_both", 1'b1, 1'b1, 1'b0, 8'h77);
    for (int i = 0; i < DP - 1; i++)
      step("drain2", 1'b0, 1'b1, 1'b0, 8'h00);
    step("empty_both", 1'b1, 1'b1, 1'b0, 8'h99);
    step("pop_one", 1'b0, 1'b1, 1'b0, 8'h00);

    for (int i = 0; i < 10; i++)
      step("wrap_w10", 1'b1, 1'b0, 1'b0, DW'(8'h80 + i));
    for (int i = 0; i < 10; i++)
      step("wrap_r10", 1'b0, 1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 12; i++)
      step("wrap_w12", 1'b1, 1'b0, 1'b0, DW'(8'hC0 + i));
    for (int i = 0; i < 12; i++)
      step("wrap_r12", 1'b0, 1'b1, 1'b0, 8'h00);

    for (int i = 0; i < 7; i++)
      step("pre_clr", 1'b1, 1'b0, 1'b0, DW'(8'h10 + i));
    step("clr", 1'b1, 1'b1, 1'b1, 8'h55);
    step("post_clr", 1'b0, 1'b1, 1'b0, 8'h00);

    step("fwft_w", 1'b1, 1'b0, 1'b0, 8'hA5);
    step("fwft_idle", 1'b0, 1'b0, 1'b0, 8'h00);
    step("fwft_ack", 1'b0, 1'b1, 1'b0, 8'h00);

    for (int i = 0; i < 400; i++) begin
      logic w;
      logic r;
      logic c;
      w = ($urandom_range(0, 99) < 55);
      r = ($urandom_range(0, 99) < 45);
      c = ($urandom_range(0, 63) == 0);
      step("rand", w, r, c, DW'($urandom));
    end

    for (int i = 0; i < 9; i++)
      step("burst", 1'b1, 1'b0, 1'b0, DW'($urandom));
    step("burst_rd", 1'b1, 1'b1, 1'b0, DW'($urandom));
    wr_en   = 1'b1;
    data_in = 8'h3C;
    @(posedge clk);
    #3;
    rst_an = 1'b0;
    model_reset();
    #1;
    check_all("async_rst");
    wr_en = 1'b0;
    @(posedge clk);
    #1;
    check_all("rst_held");
    rst_an = 1'b1;
    step("after_rst", 1'b1, 1'b0, 1'b0, 8'h5A);
    step("after_rst_rd", 1'b0, 1'b1, 1'b0, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
